// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU's single memory port. It combines a word-addressed RAM
// with a memory-mapped I/O window: LEDs, switches, a free-running cycle counter and a countdown timer.
module mem_io_responder #(
  parameter int    WIDTH     = 16,
  parameter int    RAM_BITS  = 10,
  parameter string INIT_FILE = "",
  parameter int    SW_WIDTH  = 10,
  parameter int    LED_WIDTH = 10
) (
  input  logic                 clk50MHz,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     mem_addr,
  input  logic [WIDTH-1:0]     writedata,
  input  logic                 memwrite,
  output logic [WIDTH-1:0]     mem_out,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 timer_expired
);

  localparam int RAM_DEPTH = 2 ** RAM_BITS;

  localparam logic [WIDTH-1:0] ADDR_LEDS   = WIDTH'(16'hFFF0);
  localparam logic [WIDTH-1:0] ADDR_SW     = WIDTH'(16'hFFF1);
  localparam logic [WIDTH-1:0] ADDR_CYCLES = WIDTH'(16'hFFF2);
  localparam logic [WIDTH-1:0] ADDR_TIMER  = WIDTH'(16'hFFF3);
  localparam logic [WIDTH-1:0] ADDR_STATUS = WIDTH'(16'hFFF4);

  typedef enum logic {
    T_IDLE,
    T_RUN
  } timer_state_t;

  logic [WIDTH-1:0]    ram [RAM_DEPTH];
  logic [RAM_BITS-1:0] ram_idx;
  logic                ram_sel;

  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [WIDTH-1:0]    cycle_count;
  logic [WIDTH-1:0]    timer_count;
  timer_state_t        timer_state;

  logic                led_wr;
  logic                timer_wr;
  logic                status_wr;
  logic                expire_now;
  logic                expired_nxt;
  logic [WIDTH-1:0]    read_data;

  assign ram_idx = mem_addr[RAM_BITS-1:0];
  assign ram_sel = (mem_addr[WIDTH-1:RAM_BITS] == '0);

  // NOTE: the RAM array has no reset branch; clearing it would turn the block RAM into
  // thousands of flops, and its contents must survive a reset anyway.
  always_ff @(posedge clk50MHz) begin
    if (!reset && memwrite && ram_sel) begin
      ram[ram_idx] <= writedata;
    end
  end

  // A timer reload on the same edge as the 1->0 step suppresses the expiry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one
    // unassigned and infer a latch.
    led_wr      = 1'b0;
    timer_wr    = 1'b0;
    status_wr   = 1'b0;
    expire_now  = 1'b0;
    expired_nxt = 1'b0;
    read_data   = '0;

    led_wr      = memwrite && (mem_addr == ADDR_LEDS);
    timer_wr    = memwrite && (mem_addr == ADDR_TIMER);
    status_wr   = memwrite && (mem_addr == ADDR_STATUS);
    expire_now  = (timer_state == T_RUN) && (timer_count == WIDTH'(1)) && !timer_wr;
    expired_nxt = expire_now || (timer_expired && !status_wr);

    // Write-first: a write in this cycle is what the registered read returns.
    if (ram_sel) begin
      read_data = memwrite ? writedata : ram[ram_idx];
    end else begin
      case (mem_addr)
        ADDR_LEDS:   read_data = memwrite ? WIDTH'(writedata[LED_WIDTH-1:0]) : WIDTH'(leds);
        ADDR_SW:     read_data = WIDTH'(sw_sync);
        ADDR_CYCLES: read_data = cycle_count;
        ADDR_TIMER:  read_data = memwrite ? writedata : timer_count;
        ADDR_STATUS: read_data = WIDTH'(expired_nxt);
        default:     read_data = '0;
      endcase
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk50MHz) begin
    if (reset) begin
      mem_out       <= '0;
      leds          <= '0;
      timer_expired <= 1'b0;
      cycle_count   <= '0;
      timer_count   <= '0;
      timer_state   <= T_IDLE;
      sw_meta       <= '0;
      sw_sync       <= '0;
    end else begin
      mem_out       <= read_data;
      cycle_count   <= cycle_count + WIDTH'(1);
      sw_meta       <= switches;
      sw_sync       <= sw_meta;
      timer_expired <= expired_nxt;

      if (led_wr) begin
        leds <= writedata[LED_WIDTH-1:0];
      end

      if (timer_wr) begin
        timer_count <= writedata;
        timer_state <= (writedata != '0) ? T_RUN : T_IDLE;
      end else begin
        case (timer_state)
          T_RUN: begin
            timer_count <= timer_count - WIDTH'(1);
            if (timer_count == WIDTH'(1)) begin
              timer_state <= T_IDLE;
            end
          end
          default: timer_state <= T_IDLE;
        endcase
      end
    end
  end

endmodule
